// File: rtl/snax_shell_pkg.sv
// Shared types and constants for the SNAX stream control shell.
// Lifecycle states, channel-mask bit offsets and read-only CSR indices.
package snax_shell_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        RUN,
        DRAIN
    } state_e;

    localparam int InMaskLsb  = 0;
    localparam int OutMaskLsb = 16;

    localparam int RoBusy   = 0;
    localparam int RoCycles = 1;
    localparam int RoStall  = 2;

endpackage

// File: rtl/snax_shell_fifo.sv
// Per-channel output buffer between a core output port and its streamer.
// The head entry drives data_o; count is registered so full_o is glitch-free.
module snax_shell_fifo #(
    parameter int unsigned DataWidth = 512,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 valid_o,
    output logic                 full_o
);

    localparam int unsigned PtrW = $clog2(FifoDepth);
    localparam int unsigned CntW = PtrW + 1;

    logic [DataWidth-1:0] mem [FifoDepth];
    logic [PtrW-1:0]      wptr;
    logic [PtrW-1:0]      rptr;
    logic [CntW-1:0]      cnt;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_i) wptr <= wptr + PtrW'(1);
            if (pop_i)  rptr <= rptr + PtrW'(1);
            cnt <= cnt + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wptr] <= data_i;
    end

    assign data_o  = mem[rptr];
    assign valid_o = (cnt != '0);
    assign full_o  = (cnt == CntW'(FifoDepth));

endmodule

// File: rtl/snax_stream_shell_ctrl.sv
// Control shell between CSR manager / streamers and a SNAX accelerator core.
// Define SNAX_SHELL_STALL_CNT_EN to add the output back-pressure counter (RO2).
module snax_stream_shell_ctrl
    import snax_shell_pkg::*;
#(
    parameter int unsigned NumIn        = 14,
    parameter int unsigned NumOut       = 4,
    parameter int unsigned DataWidth    = 512,
    parameter int unsigned FifoDepth    = 4,
    parameter int unsigned RegRWCount   = 6,
    parameter int unsigned RegROCount   = 3,
    parameter int unsigned RegDataWidth = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_ni,
    input  logic [RegRWCount*RegDataWidth-1:0]      csr_reg_set_i,
    input  logic                                    csr_reg_set_valid_i,
    output logic                                    csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0]      csr_reg_ro_set_o,
    output logic [(RegRWCount-1)*RegDataWidth-1:0]  core_cfg_o,
    output logic                                    core_cfg_valid_o,
    input  logic                                    core_cfg_ready_i,
    input  logic                                    core_done_i,
    input  logic [NumIn*DataWidth-1:0]              stream2acc_data_i,
    input  logic [NumIn-1:0]                        stream2acc_valid_i,
    output logic [NumIn-1:0]                        stream2acc_ready_o,
    output logic [NumIn*DataWidth-1:0]              core_in_data_o,
    output logic [NumIn-1:0]                        core_in_valid_o,
    input  logic [NumIn-1:0]                        core_in_ready_i,
    input  logic [NumOut*DataWidth-1:0]             core_out_data_i,
    input  logic [NumOut-1:0]                       core_out_valid_i,
    output logic [NumOut-1:0]                       core_out_ready_o,
    output logic [NumOut*DataWidth-1:0]             acc2stream_data_o,
    output logic [NumOut-1:0]                       acc2stream_valid_o,
    input  logic [NumOut-1:0]                       acc2stream_ready_i
);

    localparam int unsigned CfgW = (RegRWCount - 1) * RegDataWidth;

    state_e                  state;
    logic                    set_ready_q;
    logic                    cfg_valid_q;
    logic [CfgW-1:0]         cfg_q;
    logic [RegDataWidth-1:0] mask_q;
    logic [RegDataWidth-1:0] cyc_cnt;
    logic [RegDataWidth-1:0] stall_word;
    logic                    launch;
    logic                    active;
    logic                    busy;
    logic                    drain_ok;
    logic                    unused_mask;
    logic [NumIn-1:0]        in_gate;
    logic [NumOut-1:0]       out_en;
    logic [NumOut-1:0]       fifo_full;
    logic [NumOut-1:0]       fifo_push;
    logic [NumOut-1:0]       fifo_pop;

    assign launch   = (state == IDLE) && set_ready_q && csr_reg_set_valid_i;
    assign active   = (state == RUN) || (state == DRAIN);
    assign busy     = (state != IDLE);
    assign out_en   = mask_q[OutMaskLsb +: NumOut];
    assign in_gate  = {NumIn{state == RUN}} & mask_q[InMaskLsb +: NumIn];
    assign drain_ok = !(|acc2stream_valid_o) && !(|(core_out_valid_i & out_en));
    // Mask bits outside the channel ranges are reserved.
    assign unused_mask = ^mask_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            set_ready_q <= 1'b0;
            cfg_valid_q <= 1'b0;
            cfg_q       <= '0;
            mask_q      <= '0;
            cyc_cnt     <= '0;
        end else begin
            if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + RegDataWidth'(1);
            unique case (state)
                IDLE: begin
                    set_ready_q <= 1'b1;
                    if (launch) begin
                        cfg_q       <= csr_reg_set_i[CfgW-1:0];
                        mask_q      <= csr_reg_set_i[CfgW +: RegDataWidth];
                        cyc_cnt     <= '0;
                        set_ready_q <= 1'b0;
                        cfg_valid_q <= 1'b1;
                        state       <= CFG;
                    end
                end
                CFG: begin
                    if (core_cfg_ready_i) begin
                        cfg_valid_q <= 1'b0;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (core_done_i) state <= DRAIN;
                end
                DRAIN: begin
                    if (drain_ok) begin
                        set_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end
            endcase
        end
    end

    assign csr_reg_set_ready_o = set_ready_q;
    assign core_cfg_valid_o    = cfg_valid_q;
    assign core_cfg_o          = cfg_q;

    assign core_in_data_o     = stream2acc_data_i;
    assign core_in_valid_o    = stream2acc_valid_i & in_gate;
    assign stream2acc_ready_o = core_in_ready_i & in_gate;

    // Disabled outputs are drained and dropped so the core never stalls on them.
    for (genvar j = 0; j < NumOut; j++) begin : g_out
        assign core_out_ready_o[j] = active && (!out_en[j] || !fifo_full[j]);
        assign fifo_push[j] = core_out_valid_i[j] && active && out_en[j] && !fifo_full[j];
        assign fifo_pop[j]  = acc2stream_valid_o[j] && acc2stream_ready_i[j];

        snax_shell_fifo #(
            .DataWidth (DataWidth),
            .FifoDepth (FifoDepth)
        ) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .push_i  (fifo_push[j]),
            .data_i  (core_out_data_i[j*DataWidth +: DataWidth]),
            .pop_i   (fifo_pop[j]),
            .data_o  (acc2stream_data_o[j*DataWidth +: DataWidth]),
            .valid_o (acc2stream_valid_o[j]),
            .full_o  (fifo_full[j])
        );
    end

`ifdef SNAX_SHELL_STALL_CNT_EN
    logic [RegDataWidth-1:0] stall_cnt;
    logic                    stall;

    assign stall = active && |(acc2stream_valid_o & ~acc2stream_ready_i & out_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt <= '0;
        end else if (launch) begin
            stall_cnt <= '0;
        end else if (stall && stall_cnt != '1) begin
            stall_cnt <= stall_cnt + RegDataWidth'(1);
        end
    end

    assign stall_word = stall_cnt;
`else
    assign stall_word = '0;
`endif

    for (genvar k = 0; k < RegROCount; k++) begin : g_ro
        if (k == RoBusy) begin : g_busy
            assign csr_reg_ro_set_o[k*RegDataWidth +: RegDataWidth] =
                {{(RegDataWidth-1){1'b0}}, busy};
        end else if (k == RoCycles) begin : g_cyc
            assign csr_reg_ro_set_o[k*RegDataWidth +: RegDataWidth] = cyc_cnt;
        end else if (k == RoStall) begin : g_stall
            assign csr_reg_ro_set_o[k*RegDataWidth +: RegDataWidth] = stall_word;
        end else begin : g_zero
            assign csr_reg_ro_set_o[k*RegDataWidth +: RegDataWidth] = '0;
        end
    end

endmodule
